// File: rtl/im_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port of the program loader.
// master = host/memory side, slave = loader side.
interface im_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_data;
  logic              W_IM;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  im_addr,
    input  im_data,
    input  W_IM
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output im_addr,
    output im_data,
    output W_IM
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: parses A5/count/payload/xor-checksum frames into 32-bit words, one IM write per word the cycle after its 4th byte.
// Backpressure: rx_ready drops only in the single write cycle, so at most one word per 5 cycles; the processor is held until a clean load.
module im_loader #(
  parameter int ADDR_W     = 8,
  parameter bit TYPE_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  im_loader_if.slave bus,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int         MAX_WORDS = (ADDR_W >= 8) ? 255 : (1 << ADDR_W);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_COUNT = 2'b01;
  localparam logic [1:0] ERR_TYPE  = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        err_nxt;

  logic [31:0]       asm_word;
  logic [31:0]       word_nxt;
  logic [1:0]        byte_cnt;
  logic [7:0]        words_left;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] word_idx;

  logic              accept;
  logic              at_rest;
  logic              sync_seen;
  logic              word_full;
  logic              bad_count;
  logic              bad_type;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign at_rest   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign sync_seen = at_rest && accept && (bus.rx_data == SYNC_BYTE);
  assign word_nxt  = {asm_word[23:0], bus.rx_data};
  assign word_full = (byte_cnt == 2'd3);
  assign bad_count = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > MAX_WORDS);

  // The decoder has no class for 011, 101, 111: every odd type code except 001.
  assign bad_type  = TYPE_CHECK && word_nxt[29] && (word_nxt[31:30] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (sync_seen) begin
          state_nxt = S_COUNT;
          err_nxt   = ERR_NONE;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (bad_count) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_COUNT;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && word_full) begin
          if (bad_type) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_TYPE;
          end else begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        state_nxt = (words_left == 8'd1) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.rx_data == csum) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_CSUM;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: words_left counts down to the frame's last word, word_idx is the write address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_word   <= '0;
      byte_cnt   <= '0;
      words_left <= '0;
      csum       <= '0;
      word_idx   <= '0;
    end else begin
      if (sync_seen) begin
        word_idx <= '0;
        byte_cnt <= '0;
        csum     <= '0;
      end
      if ((state == S_COUNT) && accept) begin
        words_left <= bus.rx_data;
      end
      if ((state == S_DATA) && accept) begin
        asm_word <= word_nxt;
        csum     <= csum ^ bus.rx_data;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_WRITE) begin
        word_idx   <= word_idx + ADDR_W'(1);
        words_left <= words_left - 8'd1;
      end
    end
  end

  // Status and strobes decode straight from the state register so reset clears them at once.
  assign bus.rx_ready = (state != S_WRITE);
  assign bus.W_IM     = (state == S_WRITE);
  assign bus.im_addr  = word_idx;
  assign bus.im_data  = asm_word;
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERROR);
  assign cpu_hold     = (state != S_DONE);

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: frame table, multi-cycle hand sequences and a random byte stream against a frame-level reference model.
// Two instances share the stream: dut_a with type checking, dut_b without.
module tb_im_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(8)) ifa ();
  im_loader_if #(.ADDR_W(8)) ifb ();

  logic       hold_a, done_a, err_a;
  logic [1:0] code_a;
  logic       hold_b, done_b, err_b;
  logic [1:0] code_b;

  im_loader #(.ADDR_W(8), .TYPE_CHECK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .cpu_hold(hold_a), .done(done_a), .error(err_a), .err_code(code_a)
  );

  im_loader #(.ADDR_W(8), .TYPE_CHECK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .cpu_hold(hold_b), .done(done_b), .error(err_b), .err_code(code_b)
  );

  typedef struct packed {
    logic       hold;
    logic       done;
    logic       err;
    logic [1:0] code;
  } st_t;

  localparam st_t ST_BUSY = 5'b10000;
  localparam st_t ST_DONE = 5'b01000;
  localparam st_t ST_E01  = 5'b10101;
  localparam st_t ST_E10  = 5'b10110;
  localparam st_t ST_E11  = 5'b10111;

  typedef logic [7:0]  bq_t[$];
  typedef logic [39:0] wq_t[$];

  typedef struct {
    string        name;
    int           len;
    logic [127:0] frame;
    int           nw_a;
    logic [31:0]  last_a;
    st_t          st_a;
    int           nw_b;
    logic [31:0]  last_b;
    st_t          st_b;
  } vec_t;

  int  n_total = 0;
  int  n_pass  = 0;
  wq_t wq_a, wq_b;
  bq_t stream;
  int  rdy_low_a = 0;

  always @(negedge clk) begin
    if (!reset && ifa.W_IM) wq_a.push_back({ifa.im_addr, ifa.im_data});
    if (!reset && ifb.W_IM) wq_b.push_back({ifb.im_addr, ifb.im_data});
    if (!reset && !ifa.rx_ready) rdy_low_a++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic st_t dut_st(input bit use_b);
    return use_b ? st_t'({hold_b, done_b, err_b, code_b}) : st_t'({hold_a, done_a, err_a, code_a});
  endfunction

  // Frame-level model: walks the whole byte stream since reset and lists every expected write.
  function automatic void ref_model(input bq_t s, input bit tc, output wq_t wr, output st_t st);
    int          p;
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    bit          aborted;
    bit          truncated;
    wr = {};
    st = ST_BUSY;
    p  = 0;
    while (p < s.size()) begin
      if (s[p] != 8'hA5) begin
        p++;
        continue;
      end
      p++;
      st = ST_BUSY;
      if (p >= s.size()) break;
      n = int'(s[p]);
      p++;
      if (n == 0 || n > 255) begin
        st = ST_E01;
        continue;
      end
      x = 8'h00;
      aborted = 0;
      truncated = 0;
      for (int k = 0; k < n; k++) begin
        if (p + 4 > s.size()) begin
          truncated = 1;
          break;
        end
        w = {s[p], s[p+1], s[p+2], s[p+3]};
        x = x ^ s[p] ^ s[p+1] ^ s[p+2] ^ s[p+3];
        p += 4;
        if (tc && (w[31:29] inside {3'b011, 3'b101, 3'b111})) begin
          st = ST_E10;
          aborted = 1;
          break;
        end
        wr.push_back({8'(k), w});
      end
      if (truncated) break;
      if (aborted) continue;
      if (p >= s.size()) break;
      st = (s[p] == x) ? ST_DONE : ST_E11;
      p++;
    end
  endfunction

  task automatic idle(input int n);
    ifa.rx_valid = 1'b0;
    ifb.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte to both DUTs so that each accepts it exactly once; an unready DUT keeps valid high.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    ifa.rx_data = b;
    ifb.rx_data = b;
    while (!(ifa.rx_ready && ifb.rx_ready)) begin
      ifa.rx_valid = !ifa.rx_ready;
      ifb.rx_valid = !ifb.rx_ready;
      @(negedge clk);
      guard++;
      if (guard > 16) begin
        check("handshake_timeout", 64'(guard), 64'(0));
        return;
      end
    end
    ifa.rx_valid = 1'b1;
    ifb.rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, 64'(ifa.rx_ready), 64'(1));
    check({tag, "_cpu_hold"}, 64'(hold_a), 64'(1));
    check({tag, "_W_IM"}, 64'(ifa.W_IM), 64'(0));
    check({tag, "_done"}, 64'(done_a), 64'(0));
    check({tag, "_error"}, 64'(err_a), 64'(0));
    check({tag, "_err_code"}, 64'(code_a), 64'(0));
    check({tag, "_im_addr"}, 64'(ifa.im_addr), 64'(0));
    check({tag, "_im_data"}, 64'(ifa.im_data), 64'(0));
  endtask

  task automatic compare_model(input bit use_b, input string tag, inout int seen);
    wq_t exp;
    wq_t got;
    st_t est;
    ref_model(stream, !use_b, exp, est);
    got = use_b ? wq_b : wq_a;
    check({tag, "_nwrites"}, 64'(got.size()), 64'(exp.size()));
    for (int k = seen; k < exp.size() && k < got.size(); k++)
      check($sformatf("%s_write%0d", tag, k), 64'(got[k]), 64'(exp[k]));
    seen = exp.size();
    check({tag, "_status"}, 64'(dut_st(use_b)), 64'(est));
  endtask

  task automatic send_rand(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) idle(1);
    send_byte(b);
    stream.push_back(b);
  endtask

  function automatic vec_t mk(input string nm, input int len, input logic [127:0] fr,
                              input int na, input logic [31:0] la, input st_t sa,
                              input int nb, input logic [31:0] lb, input st_t sb);
    vec_t v;
    v.name = nm; v.len = len; v.frame = fr;
    v.nw_a = na; v.last_a = la; v.st_a = sa;
    v.nw_b = nb; v.last_b = lb; v.st_b = sb;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vt[9];
    logic [127:0] frm;
    int           r0;
    int           r1;
    int           seen_a;
    int           seen_b;

    vt[0] = mk("single",   7,  128'hA5_01_20_00_00_01_21, 1, 32'h20000001, ST_DONE, 1, 32'h20000001, ST_DONE);
    vt[1] = mk("type011",  7,  128'hA5_01_60_00_00_00_60, 0, 32'h0, ST_E10, 1, 32'h60000000, ST_DONE);
    vt[2] = mk("badcsum",  7,  128'hA5_01_20_00_00_01_22, 1, 32'h20000001, ST_E11, 1, 32'h20000001, ST_E11);
    vt[3] = mk("count0",   2,  128'hA5_00, 0, 32'h0, ST_E01, 0, 32'h0, ST_E01);
    vt[4] = mk("three",    15, 128'hA5_03_00_11_22_33_44_55_66_77_C8_99_AA_BB_40,
               3, 32'hC899AABB, ST_DONE, 3, 32'hC899AABB, ST_DONE);
    vt[5] = mk("garbage",  9,  128'h00_5A_A5_01_1F_FF_00_0E_EE, 1, 32'h1FFF000E, ST_DONE, 1, 32'h1FFF000E, ST_DONE);
    vt[6] = mk("type111",  11, 128'hA5_02_40_00_00_00_E0_00_00_00_A0,
               1, 32'h40000000, ST_E10, 2, 32'hE0000000, ST_DONE);
    vt[7] = mk("type101",  7,  128'hA5_01_A0_00_00_06_A6, 0, 32'h0, ST_E10, 1, 32'hA0000006, ST_DONE);
    vt[8] = mk("type011b", 7,  128'hA5_01_7F_00_00_00_7F, 0, 32'h0, ST_E10, 1, 32'h7F000000, ST_DONE);

    ifa.rx_valid = 1'b0; ifb.rx_valid = 1'b0;
    ifa.rx_data  = 8'h00; ifb.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1'b0;
    idle(3);
    check("hold_before_load", 64'(hold_a), 64'(1));

    // Table of whole frames.
    for (int i = 0; i < 9; i++) begin
      wq_a.delete();
      wq_b.delete();
      frm = vt[i].frame;
      for (int j = 0; j < vt[i].len; j++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        send_byte(frm[8*(vt[i].len-1-j) +: 8]);
      end
      idle(3);
      check({vt[i].name, "_a_nw"}, 64'(wq_a.size()), 64'(vt[i].nw_a));
      check({vt[i].name, "_a_st"}, 64'(dut_st(0)), 64'(vt[i].st_a));
      if (vt[i].nw_a > 0 && wq_a.size() > 0)
        check({vt[i].name, "_a_last"}, 64'(wq_a[wq_a.size()-1]), 64'({8'(vt[i].nw_a - 1), vt[i].last_a}));
      check({vt[i].name, "_b_nw"}, 64'(wq_b.size()), 64'(vt[i].nw_b));
      check({vt[i].name, "_b_st"}, 64'(dut_st(1)), 64'(vt[i].st_b));
      if (vt[i].nw_b > 0 && wq_b.size() > 0)
        check({vt[i].name, "_b_last"}, 64'(wq_b[wq_b.size()-1]), 64'({8'(vt[i].nw_b - 1), vt[i].last_b}));
    end

    // Back-to-back words with rx_valid held high throughout.
    wq_a.delete();
    #1 r0 = rdy_low_a;
    @(negedge clk);
    frm = vt[4].frame;
    for (int j = 0; j < 15; j++) send_byte(frm[8*(14-j) +: 8]);
    idle(3);
    #1 r1 = rdy_low_a;
    check("bp_ready_low_cycles", 64'(r1 - r0), 64'(3));
    check("bp_nwrites", 64'(wq_a.size()), 64'(3));
    if (wq_a.size() == 3) begin
      check("bp_w0", 64'(wq_a[0]), 64'({8'd0, 32'h00112233}));
      check("bp_w1", 64'(wq_a[1]), 64'({8'd1, 32'h44556677}));
      check("bp_w2", 64'(wq_a[2]), 64'({8'd2, 32'hC899AABB}));
    end
    check("bp_done", 64'(dut_st(0)), 64'(ST_DONE));
    @(negedge clk);

    // Reload after DONE, cycle by cycle.
    send_byte(8'hA5);
    check("reload_hold_rises", 64'(hold_a), 64'(1));
    check("reload_done_clears", 64'(done_a), 64'(0));
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    check("reload_no_early_write", 64'(ifa.W_IM), 64'(0));
    send_byte(8'h01);
    check("reload_W_IM", 64'(ifa.W_IM), 64'(1));
    check("reload_addr", 64'(ifa.im_addr), 64'(0));
    check("reload_data", 64'(ifa.im_data), 64'(32'h20000001));
    idle(1);
    check("reload_W_IM_one_cycle", 64'(ifa.W_IM), 64'(0));
    send_byte(8'h21);
    check("reload_done_rises", 64'(dut_st(0)), 64'(ST_DONE));
    idle(2);

    // Reset after the 2nd payload byte.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    ifa.rx_valid = 1'b0; ifb.rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset("midframe_reset");
    @(negedge clk);
    reset = 1'b0;
    wq_a.delete(); wq_b.delete();
    frm = vt[0].frame;
    for (int j = 0; j < 7; j++) send_byte(frm[8*(6-j) +: 8]);
    idle(3);
    check("after_reset_nw", 64'(wq_a.size()), 64'(1));
    if (wq_a.size() == 1) check("after_reset_w0", 64'(wq_a[0]), 64'({8'd0, 32'h20000001}));
    check("after_reset_st", 64'(dut_st(0)), 64'(ST_DONE));

    // Reset landing inside the write cycle.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    check("wr_reset_in_write", 64'(ifa.W_IM), 64'(1));
    ifa.rx_valid = 1'b0; ifb.rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset("write_reset");
    @(negedge clk);
    reset = 1'b0;
    wq_a.delete();
    idle(3);
    check("write_reset_no_write", 64'(wq_a.size()), 64'(0));
    check("write_reset_st", 64'(dut_st(0)), 64'(ST_BUSY));

    // Random frames against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wq_a.delete(); wq_b.delete();
    stream.delete();
    seen_a = 0;
    seen_b = 0;
    for (int f = 0; f < 40; f++) begin
      int          nwd;
      logic [7:0]  cs;
      logic [7:0]  bt;
      logic [31:0] w;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bt = 8'($urandom);
        send_rand((bt == 8'hA5) ? 8'h00 : bt);
      end
      send_rand(8'hA5);
      nwd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      send_rand(8'(nwd));
      cs = 8'h00;
      for (int k = 0; k < nwd; k++) begin
        w = $urandom;
        for (int j = 3; j >= 0; j--) begin
          cs = cs ^ w[8*j +: 8];
          send_rand(w[8*j +: 8]);
        end
      end
      if (nwd > 0) begin
        if ($urandom_range(0, 5) == 0) cs = cs ^ 8'(1 + $urandom_range(0, 254));
        send_rand(cs);
      end
      idle(3);
      compare_model(1'b0, $sformatf("rnd%0d_a", f), seen_a);
      compare_model(1'b1, $sformatf("rnd%0d_b", f), seen_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
